ov5640_dvp_tx: RTL

//  DVP source, the transmit side of the OV5640 camera bus. Takes 16-bit RGB565 pixels from a

---
 rtl/ov5640_pkg.sv | 22 ++
 rtl/ov5640_dvp_timing.sv | 96 +++++++++
 rtl/ov5640_dvp_tx.sv | 89 ++++++++
 3 files changed

// File: rtl/ov5640_pkg.sv
// Shared types and default timing for the OV5640 DVP emulator and its capture side.
package ov5640_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} dvp_state_t;

    localparam int DVP_H_ACTIVE    = 640;
    localparam int DVP_V_ACTIVE    = 480;
    localparam int DVP_H_BLANK     = 64;
    localparam int DVP_VSYNC_LINES = 4;
    localparam int DVP_V_BACK      = 8;
    localparam int DVP_V_FRONT     = 4;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ov5640_dvp_timing.sv
// Frame/line sequencer for the DVP source: owns the state machine and the h/v counters.
module ov5640_dvp_timing
    import ov5640_pkg::*;
#(
    parameter int H_ACTIVE    = DVP_H_ACTIVE,
    parameter int V_ACTIVE    = DVP_V_ACTIVE,
    parameter int H_BLANK     = DVP_H_BLANK,
    parameter int VSYNC_LINES = DVP_VSYNC_LINES,
    parameter int V_BACK      = DVP_V_BACK,
    parameter int V_FRONT     = DVP_V_FRONT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_in_vsync,
    output logic o_in_href_window,
    output logic o_even_slot,
    output logic o_frame_first_cycle
);

    localparam int L    = 2 * H_ACTIVE + H_BLANK;
    localparam int HW   = (L > 1) ? $clog2(L) : 1;
    localparam int MAXL = max4(V_ACTIVE, VSYNC_LINES, V_BACK, V_FRONT);
    localparam int VW   = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

    dvp_state_t    r_state;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    dvp_state_t    w_next;
    logic          w_line_end;
    logic          w_state_end;

    function automatic int lines_of(input dvp_state_t s);
        case (s)
            VSYNC:   return VSYNC_LINES;
            VBACK:   return V_BACK;
            ACTIVE:  return V_ACTIVE;
            VFRONT:  return V_FRONT;
            default: return 0;
        endcase
    endfunction

    // Walk past zero-length states; an empty front porch decides VSYNC/IDLE on the spot.
    function automatic dvp_state_t resolve(input dvp_state_t s, input logic en);
        dvp_state_t t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t == VSYNC && VSYNC_LINES == 0)      t = VBACK;
            else if (t == VBACK && V_BACK == 0)      t = ACTIVE;
            else if (t == VFRONT && V_FRONT == 0)    t = en ? VSYNC : IDLE;
        end
        return t;
    endfunction

    assign w_line_end  = (int'(r_h_cnt) == L - 1);
    assign w_state_end = w_line_end && (int'(r_v_cnt) == lines_of(r_state) - 1);

    always_comb begin
        w_next = IDLE;
        case (r_state)
            VSYNC:   w_next = resolve(VBACK, i_enable);
            VBACK:   w_next = resolve(ACTIVE, i_enable);
            ACTIVE:  w_next = resolve(VFRONT, i_enable);
            VFRONT:  w_next = resolve(i_enable ? VSYNC : IDLE, i_enable);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            if (i_enable) r_state <= resolve(VSYNC, i_enable);
        end else if (w_line_end) begin
            r_h_cnt <= '0;
            if (w_state_end) begin
                r_v_cnt <= '0;
                r_state <= w_next;
            end else begin
                r_v_cnt <= r_v_cnt + VW'(1);
            end
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign o_in_vsync          = (r_state == VSYNC);
    assign o_in_href_window    = (r_state == ACTIVE) && (int'(r_h_cnt) < 2 * H_ACTIVE);
    assign o_even_slot         = ~r_h_cnt[0];
    assign o_frame_first_cycle = (r_state == VSYNC) && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/ov5640_dvp_tx.sv
// DVP transmitter: turns an RGB565 valid/ready stream into vsync/href/byte frames, high byte first.
module ov5640_dvp_tx
    import ov5640_pkg::*;
#(
    parameter int H_ACTIVE    = DVP_H_ACTIVE,
    parameter int V_ACTIVE    = DVP_V_ACTIVE,
    parameter int H_BLANK     = DVP_H_BLANK,
    parameter int VSYNC_LINES = DVP_VSYNC_LINES,
    parameter int V_BACK      = DVP_V_BACK,
    parameter int V_FRONT     = DVP_V_FRONT
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_start,
    output logic        underflow
);

    logic       w_in_vsync;
    logic       w_in_window;
    logic       w_even;
    logic       w_first;
    logic       w_xfer;
    logic       r_vsync;
    logic       r_href;
    logic [7:0] r_data;
    logic [7:0] r_lo;
    logic       r_fs;
    logic       r_uf;

    ov5640_dvp_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .i_clk               (clk),
        .i_rst               (rest),
        .i_enable            (enable),
        .o_in_vsync          (w_in_vsync),
        .o_in_href_window    (w_in_window),
        .o_even_slot         (w_even),
        .o_frame_first_cycle (w_first)
    );

    assign pix_ready = w_in_window & w_even;
    assign w_xfer    = pix_ready & pix_valid;

    // A missed slot still occupies its two byte times, sent as zeros, so line timing never moves.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_data  <= 8'h00;
            r_lo    <= 8'h00;
            r_fs    <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            r_vsync <= w_in_vsync;
            r_fs    <= w_first;
            r_href  <= w_in_window;
            r_uf    <= 1'b0;
            if (!w_in_window) begin
                r_data <= 8'h00;
            end else if (w_even) begin
                r_data <= w_xfer ? pix_data[15:8] : 8'h00;
                r_lo   <= w_xfer ? pix_data[7:0]  : 8'h00;
                r_uf   <= ~w_xfer;
            end else begin
                r_data <= r_lo;
            end
        end
    end

    assign dvp_vsync   = r_vsync;
    assign dvp_href    = r_href;
    assign dvp_data    = r_data;
    assign frame_start = r_fs;
    assign underflow   = r_uf;

endmodule
